// File: rtl/fifo_reader.sv
// Credit-limited reader for a sync FIFO with RD_LATENCY read latency; first word reaches o_data RD_LATENCY+1 cycles after the first pop.
// Holds returning words in a BUF_DEPTH ring so i_ready backpressure never overflows; i_flush drops buffered and in-flight words.
module fifo_reader #(
   parameter  int WIDTH      = 16,
   parameter  int RD_LATENCY = 1,
   localparam int BUF_DEPTH  = RD_LATENCY + 1
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   output logic                               o_fifo_rd_incr,
   input  logic [WIDTH-1:0]                   i_fifo_data,
   input  logic                               i_fifo_empty,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic [WIDTH-1:0]                   o_data,
   input  logic                               i_flush,
   output logic [$clog2(BUF_DEPTH+1)-1:0]     o_level,
   output logic [31:0]                        o_beats
);

   localparam int LVL_W = $clog2(BUF_DEPTH + 1);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int IF_W  = $clog2(RD_LATENCY + 1);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t                state_q, state_d;
   logic                  started_q;
   logic [RD_LATENCY-1:0] pend_q, pend_d;
   logic [RD_LATENCY-1:0] disc_q, disc_d;
   logic [WIDTH-1:0]      mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [31:0]           beats_q, beats_d;
   logic [IF_W-1:0]       inflight;
   logic                  flush_take;
   logic                  xfer;
   logic                  cap;
   logic                  credit_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + IF_W'(pend_q[i]);
      end
   end

   assign o_valid    = (level_q != '0);
   assign o_data     = mem_q[head_q];
   assign o_level    = level_q;
   assign o_beats    = beats_q;
   assign flush_take = i_flush && (state_q == ST_RUN);
   assign xfer       = o_valid && i_ready && !flush_take;
   // The returning pop is still counted in inflight, so a capture and a transfer in the same cycle keep one word per cycle flowing.
   assign credit_ok  = (int'(level_q) + int'(inflight) - int'(xfer)) < BUF_DEPTH;
   assign cap        = pend_q[RD_LATENCY-1] && !disc_q[RD_LATENCY-1] && !flush_take;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (i_flush) state_d = ST_FLUSH;
         ST_FLUSH: if (pend_d == '0) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_comb begin
      o_fifo_rd_incr = (state_q == ST_RUN) && started_q && !i_fifo_empty && !i_flush && credit_ok;
   end

   always_comb begin
      pend_d    = '0;
      disc_d    = '0;
      pend_d[0] = o_fifo_rd_incr;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pend_d[i] = pend_q[i-1];
         disc_d[i] = disc_q[i-1] || flush_take;
      end
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      beats_d = beats_q;
      if (flush_take) begin
         head_d  = '0;
         tail_d  = '0;
         level_d = '0;
      end else begin
         if (xfer) head_d = ptr_inc(head_q);
         if (cap)  tail_d = ptr_inc(tail_q);
         if (cap && !xfer) begin
            level_d = level_q + LVL_W'(1);
         end else if (xfer && !cap) begin
            level_d = level_q - LVL_W'(1);
         end
      end
      if (xfer) beats_d = beats_q + 32'd1;
   end

   // started_q keeps the first pop off the first edge after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         started_q <= 1'b0;
         pend_q    <= '0;
         disc_q    <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         level_q   <= '0;
         beats_q   <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         started_q <= 1'b1;
         pend_q    <= pend_d;
         disc_q    <= disc_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         level_q   <= level_d;
         beats_q   <= beats_d;
         if (cap) mem_q[tail_q] <= i_fifo_data;
      end
   end

endmodule
